// File: rtl/regfile_wb_scheduler_if.sv
// Issue / writeback / register-file bundle shared by the writeback scheduler
// and whatever drives it.
//   issue_*   : decode-side issue request; issue_ready returned by scheduler
//   alu_wb_*  : ALU writeback (no backpressure)
//   lsu_wb_*  : LSU writeback request; lsu_wb_ready returned by scheduler
//   rf_*      : register file write port driven by scheduler
//   busy      : per-register outstanding-write scoreboard
interface regfile_wb_scheduler_if #(
    parameter int unsigned N = 32
);
    logic         issue_valid;
    logic [4:0]   issue_rd;
    logic [4:0]   issue_rs1;
    logic [4:0]   issue_rs2;
    logic         issue_use_rs1;
    logic         issue_use_rs2;
    logic         issue_long;
    logic         issue_ready;

    logic         alu_wb_valid;
    logic [4:0]   alu_wb_rd;
    logic [N-1:0] alu_wb_data;

    logic         lsu_wb_valid;
    logic [4:0]   lsu_wb_rd;
    logic [N-1:0] lsu_wb_data;
    logic         lsu_wb_ready;

    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [N-1:0] rf_wdata;
    logic [31:0]  busy;

    // Driver side (decode, execution units, bench)
    modport master (
        output issue_valid, issue_rd, issue_rs1, issue_rs2,
               issue_use_rs1, issue_use_rs2, issue_long,
               alu_wb_valid, alu_wb_rd, alu_wb_data,
               lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
        input  issue_ready, lsu_wb_ready, rf_we, rf_waddr, rf_wdata, busy
    );

    // Scheduler side
    modport slave (
        input  issue_valid, issue_rd, issue_rs1, issue_rs2,
               issue_use_rs1, issue_use_rs2, issue_long,
               alu_wb_valid, alu_wb_rd, alu_wb_data,
               lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
        output issue_ready, lsu_wb_ready, rf_we, rf_waddr, rf_wdata, busy
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler with scoreboard.
//   clk   : single clock, rising edge
//   rst   : asynchronous active-low reset
//   bus   : regfile_wb_scheduler_if.slave
//           - issue handshake gated by RAW/WAW hazards on the scoreboard and
//             by a starvation throttle
//           - ALU writeback always wins the single write port; LSU writeback
//             waits in a one-entry buffer that drains on ALU-idle cycles
//           - busy[r] high while a write to xr is outstanding (busy[0] = 0)
module regfile_wb_scheduler #(
    parameter int unsigned N            = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_wb_scheduler_if.slave  bus
);

    localparam int unsigned AW   = 5;
    localparam int unsigned CW   = 4;
    localparam int unsigned NREG = 32;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] LIMIT   = CW'(STARVE_LIMIT);

    logic [NREG-1:0] r_busy;
    logic            r_pend_valid;
    logic [AW-1:0]   r_pend_rd;
    logic [N-1:0]    r_pend_data;
    logic [CW-1:0]   r_wait_cnt;
    logic            r_throttle;
    logic            r_drained;

    logic            w_rs1_hit;
    logic            w_rs2_hit;
    logic            w_rd_hit;
    logic            w_issue_ready;
    logic            w_issue_acc;
    logic            w_lsu_acc;
    logic            w_drain;
    logic            w_wr_en;
    logic [AW-1:0]   w_wr_addr;
    logic [N-1:0]    w_wr_data;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_busy_nxt;
    logic [CW-1:0]   w_cnt_nxt;

    // Hazard check uses only registered scoreboard/throttle, never issue_valid
    always_comb begin
        w_rs1_hit     = bus.issue_use_rs1 & r_busy[bus.issue_rs1];
        w_rs2_hit     = bus.issue_use_rs2 & r_busy[bus.issue_rs2];
        w_rd_hit      = (bus.issue_rd != '0) & r_busy[bus.issue_rd];
        w_issue_ready = ~(w_rs1_hit | w_rs2_hit | w_rd_hit | r_throttle);
        w_issue_acc   = bus.issue_valid & w_issue_ready;
    end

    // Buffer only accepts when empty at cycle start, so accept and drain never overlap
    assign w_lsu_acc = bus.lsu_wb_valid & ~r_pend_valid;
    assign w_drain   = r_pend_valid & ~bus.alu_wb_valid;

    // Write-port arbitration: ALU first, pending LSU entry on ALU-idle cycles
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        w_wr_data = '0;
        if (bus.alu_wb_valid) begin
            w_wr_addr = bus.alu_wb_rd;
            w_wr_data = bus.alu_wb_data;
            w_wr_en   = (bus.alu_wb_rd != '0);
        end else if (w_drain) begin
            w_wr_addr = r_pend_rd;
            w_wr_data = r_pend_data;
            w_wr_en   = (r_pend_rd != '0);
        end
    end

    // Scoreboard update; set and clear of one register cannot coincide (WAW stall)
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_issue_acc && (bus.issue_rd != '0)) begin
            w_set = NREG'(1) << bus.issue_rd;
        end
        if (w_wr_en) begin
            w_clr = NREG'(1) << w_wr_addr;
        end
        w_busy_nxt    = (r_busy & ~w_clr) | w_set;
        w_busy_nxt[0] = 1'b0;
    end

    // Starvation counter: saturating count of cycles a pending entry is skipped
    always_comb begin
        w_cnt_nxt = '0;
        if (r_pend_valid && !w_drain) begin
            w_cnt_nxt = (r_wait_cnt == CNT_MAX) ? r_wait_cnt : r_wait_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy       <= '0;
            r_pend_valid <= 1'b0;
            r_pend_rd    <= '0;
            r_pend_data  <= '0;
            r_wait_cnt   <= '0;
            r_throttle   <= 1'b0;
            r_drained    <= 1'b0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_wait_cnt <= w_cnt_nxt;
            r_drained  <= w_drain;
            if (w_lsu_acc) begin
                r_pend_valid <= 1'b1;
                r_pend_rd    <= bus.lsu_wb_rd;
                r_pend_data  <= bus.lsu_wb_data;
            end else if (w_drain) begin
                r_pend_valid <= 1'b0;
            end
            // Throttle releases one cycle after the drain cycle
            if (r_drained) begin
                r_throttle <= 1'b0;
            end else if (w_cnt_nxt >= LIMIT) begin
                r_throttle <= 1'b1;
            end
        end
    end

    assign bus.issue_ready  = w_issue_ready;
    assign bus.lsu_wb_ready = ~r_pend_valid;
    assign bus.rf_we        = w_wr_en;
    assign bus.rf_waddr     = w_wr_addr;
    assign bus.rf_wdata     = w_wr_data;
    assign bus.busy         = r_busy;

endmodule

// File: doc/regfile_wb_scheduler.md
REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

Interface
REQ-001 Parameter N, default 32: data width of writeback data and of the register file write port.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive cycles a pending LSU writeback may wait before issue is throttled; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 issue_valid  input  1  decode presents an instruction.
REQ-006 issue_rd, issue_rs1, issue_rs2  input  5 each  destination and source register addresses.
REQ-007 issue_use_rs1, issue_use_rs2  input  1 each  instruction reads the corresponding source.
REQ-008 issue_long  input  1  instruction writes back via the LSU port (load); else via the ALU port.
REQ-009 issue_ready  output  1  instruction accepted this cycle when issue_valid and issue_ready are both high.
REQ-010 alu_wb_valid, alu_wb_rd[4:0], alu_wb_data[N-1:0]  input  ALU writeback; no backpressure, always consumed.
REQ-011 lsu_wb_valid, lsu_wb_rd[4:0], lsu_wb_data[N-1:0]  input  LSU writeback request.
REQ-012 lsu_wb_ready  output  1  LSU writeback accepted when lsu_wb_valid and lsu_wb_ready are both high.
REQ-013 rf_we  output  1  register file write enable.
REQ-014 rf_waddr  output  5  register file write address.
REQ-015 rf_wdata  output  N  register file write data.
REQ-016 busy  output  32  scoreboard; bit r high = write to xr outstanding.

Function
REQ-017 The scoreboard SHALL hold one busy bit per register; busy[0] is constantly 0.
REQ-018 issue_ready SHALL be combinational from registered state: low if (use_rs1 and busy[rs1]) or (use_rs2 and busy[rs2]) or (rd!=0 and busy[rd]) or throttle is high; otherwise high.
REQ-019 On an accepted issue with rd!=0, busy[rd] SHALL be set at the next edge; rd=0 sets nothing.
REQ-020 The LSU port SHALL feed a one-entry pending buffer (valid, rd, data); lsu_wb_ready = not pend_valid, registered state only.
REQ-021 Write-port priority SHALL be fixed: ALU writeback first; the pending buffer drains only in a cycle with alu_wb_valid low.
REQ-022 A drained buffer SHALL become empty at the next edge; the LSU entry accepted that same edge occupies it with no bubble only if the buffer was empty at the start of the cycle (no same-cycle refill).
REQ-023 rf_we/rf_waddr/rf_wdata SHALL be combinational: granted source's rd and data; rf_we low when no grant or granted rd=0.
REQ-024 A write with rd!=0 SHALL clear busy[rd] at the next edge; a clear and a set of the same register cannot coincide (REQ-018 blocks WAW), and the clear applies before any later issue sees it, i.e. issue to that rd stalls exactly through the writeback cycle.
REQ-025 A wait counter (4 bits, saturating at 15) SHALL increment each cycle pend_valid is high and the buffer is not drained, and reset to 0 on drain or when empty.
REQ-026 throttle SHALL be registered: set when the counter reaches STARVE_LIMIT, cleared the cycle after the buffer drains.
REQ-027 Writebacks to rd not marked busy SHALL still be written and SHALL leave busy unchanged (no error flag).
REQ-028 Expected RTL size 120-400 lines; no latches, no combinational loops between issue_ready and issue_valid.

Reset
REQ-029 While rst is low: busy=0, pending buffer empty, counter=0, throttle=0; hence issue_ready follows only inputs (high unless blocked), lsu_wb_ready=1, rf_we=0 when alu_wb_valid low.
REQ-030 Reset asserted mid-operation SHALL discard the pending entry without writing it and clear all busy bits asynchronously.

Verification
REQ-031 Issue rd=5 (ALU), next cycle issue use_rs1 rs1=5 -> issue_ready=0 until alu_wb_valid rd=5 written; issue_ready=1 the cycle after, busy[5]=0.
REQ-032 Same cycle alu_wb(rd=3,0xAAAA) and lsu_wb(rd=7,0x1234) -> rf_waddr=3 that cycle, rf_waddr=7 data 0x1234 next cycle, lsu_wb_ready=0 for one cycle.
REQ-033 Pending LSU entry with alu_wb_valid held high 4 cycles (STARVE_LIMIT=4) -> throttle high, issue_ready=0; drop ALU -> LSU entry written, issue_ready=1 two cycles later.
REQ-034 Issue rd=0 and alu_wb rd=0 data 0xFFFF -> busy stays 0, rf_we=0.
REQ-035 Pending LSU entry rd=9, busy[9]=1, rst pulsed low mid-cycle -> buffer empty, busy=0, no write of rd=9 occurs after release.
REQ-036 Back-to-back accepted issues rd=1..4 with ALU writebacks in order one cycle later -> busy sequence rises then clears in order, no stall on independent sources.
